// File: rtl/mem_pkg.sv
// Shared types for the unified instruction/data memory responder: region select
// constants, the responder FSM state encoding and the wait-state counter type.
package mem_pkg;

    localparam logic REGION_ROM = 1'b0;
    localparam logic REGION_RAM = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_e;

    typedef logic [3:0] wait_cnt_t;

endpackage

// File: rtl/mem_bank.sv
// 32-bit word storage bank with a registered read port and a byte-masked write port.
// WRITE_EN=0 ties the write strobe low so the bank behaves as a read-only memory.
module mem_bank #(
    parameter int DEPTH    = 1024,
    parameter bit WRITE_EN = 1'b1,
    parameter int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;
    logic        we_eff;

    generate
        if (WRITE_EN) begin : g_wr
            assign we_eff = we_i;
        end else begin : g_ro
            assign we_eff = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_eff) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/unified_mem_responder.sv
// Memory-side responder for the shared fetch/load-store port: wait states, ROM/RAM
// access and error decode. Define MEMR_ROM_WRITE_EN to let writes program the ROM.
module unified_mem_responder
    import mem_pkg::*;
#(
    parameter int ROM_DEPTH = 1024,
    parameter int RAM_DEPTH = 1024,
    parameter int ROM_WAIT  = 0,
    parameter int RAM_WAIT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [12:0] req_addr,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int ROM_AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
`ifdef MEMR_ROM_WRITE_EN
    localparam bit ROM_WR = 1'b1;
`else
    localparam bit ROM_WR = 1'b0;
`endif

    state_e      state_q;
    wait_cnt_t   cnt_q;
    wait_cnt_t   wait_d;
    logic        region_q;
    logic        we_q;
    logic [11:0] idx_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic        err_d;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rom_en;
    logic        ram_en;
    logic [31:0] rom_rdata;
    logic [31:0] ram_rdata;

    assign wait_d = (req_addr[12] == REGION_RAM) ? wait_cnt_t'(RAM_WAIT) : wait_cnt_t'(ROM_WAIT);

    // Fault decode works on the latched request, so it is valid throughout ACCESS.
    always_comb begin
        err_d = 1'b0;
        if (region_q == REGION_RAM) begin
            err_d = ({20'd0, idx_q} >= 32'(RAM_DEPTH));
        end else begin
            err_d = ({20'd0, idx_q} >= 32'(ROM_DEPTH)) || (we_q && !ROM_WR);
        end
    end

    assign rom_en = (state_q == ACCESS) && (region_q == REGION_ROM) && !err_d;
    assign ram_en = (state_q == ACCESS) && (region_q == REGION_RAM) && !err_d;

    mem_bank #(.DEPTH(ROM_DEPTH), .WRITE_EN(ROM_WR), .AW(ROM_AW)) u_rom (
        .clk     (clk),
        .en_i    (rom_en),
        .we_i    (we_q),
        .addr_i  (idx_q[ROM_AW-1:0]),
        .be_i    (be_q),
        .wdata_i (wdata_q),
        .rdata_o (rom_rdata)
    );

    mem_bank #(.DEPTH(RAM_DEPTH), .WRITE_EN(1'b1), .AW(RAM_AW)) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (we_q),
        .addr_i  (idx_q[RAM_AW-1:0]),
        .be_i    (be_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            region_q    <= REGION_ROM;
            we_q        <= 1'b0;
            idx_q       <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        region_q    <= req_addr[12];
                        idx_q       <= req_addr[11:0];
                        we_q        <= req_we;
                        be_q        <= req_be;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (wait_d == '0) begin
                            state_q <= ACCESS;
                        end else begin
                            cnt_q   <= wait_d - 4'd1;
                            state_q <= WAIT;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= ACCESS;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ACCESS: begin
                    err_q       <= err_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        err_q       <= 1'b0;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
            endcase
        end
    end

    // Bank read registers are idle during RESP, so the selected word holds until handshake.
    assign rsp_rdata = (rsp_valid_q && !err_q && !we_q)
                       ? ((region_q == REGION_RAM) ? ram_rdata : rom_rdata)
                       : 32'd0;
    assign rsp_err   = err_q;
    assign rsp_valid = rsp_valid_q;
    assign req_ready = req_ready_q;

endmodule

// File: tb/tb_unified_mem_responder.sv
// Self-checking bench for unified_mem_responder: directed vector table, multi-cycle
// reset/backpressure sequences and randomized traffic against a word-array model.
module tb_unified_mem_responder;

    localparam int ROM_W = 0;
    localparam int RAM_W = 1;
    localparam int DEPTH = 1024;
`ifdef MEMR_ROM_WRITE_EN
    localparam bit ROMW = 1'b1;
`else
    localparam bit ROMW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [12:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [3:0]  req_be = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] rom_m [DEPTH];
    logic [31:0] ram_m [DEPTH];

    always #5 clk = ~clk;

    unified_mem_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        logic [12:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          hold;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [31:0] rom_init(input int i);
        return {16'hC0DE, 16'(i)};
    endfunction

    function automatic logic [31:0] ram_init(input int i);
        return {16'h5A5A, 16'(i)};
    endfunction

    // Reference: region/index decode, fault rules and byte-lane writes on plain arrays.
    function automatic logic [32:0] model(input logic [12:0] a, input logic we,
                                          input logic [3:0] be, input logic [31:0] wd);
        int  idx = int'(a[11:0]);
        bit  err;
        if (a[12]) err = (idx >= DEPTH);
        else       err = (idx >= DEPTH) || (we && !ROMW);
        if (err) return {1'b1, 32'd0};
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    if (a[12]) ram_m[idx][8*b +: 8] = wd[8*b +: 8];
                    else       rom_m[idx][8*b +: 8] = wd[8*b +: 8];
                end
            end
            return {1'b0, 32'd0};
        end
        return {1'b0, a[12] ? ram_m[idx] : rom_m[idx]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_txn(input string tag, input logic [12:0] a, input logic we,
                          input logic [3:0] be, input logic [31:0] wd, input int hold,
                          input logic exp_err, input logic [31:0] exp_rd);
        int n;
        int w;
        logic [31:0] got_rd;
        logic        got_err;
        w = a[12] ? RAM_W : ROM_W;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = we;
        req_be    = be;
        req_wdata = wd;
        @(posedge clk);
        #1;
        // Scramble the request bus: the responder must work from latched values.
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = 13'($urandom);
        req_we    = 1'($urandom);
        req_be    = 4'($urandom);
        req_wdata = $urandom;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({tag, " latency"}, 32'(n), 32'(w + 1));
        for (int i = 0; i < hold; i++) begin
            chk({tag, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " hold rdata"}, rsp_rdata, exp_rd);
            chk({tag, " hold err"}, 32'(rsp_err), 32'(exp_err));
            chk({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        got_rd  = rsp_rdata;
        got_err = rsp_err;
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, " rdata"}, got_rd, exp_rd);
        chk({tag, " err"}, 32'(got_err), 32'(exp_err));
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk({tag, " post rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " post req_ready"}, 32'(req_ready), 32'd1);
        $display("TXN %s addr=%h we=%0d be=%h wdata=%h hold=%0d -> rdata=%h err=%0d (exp %h/%0d)",
                 tag, a, we, be, wd, hold, got_rd, got_err, exp_rd, exp_err);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [32:0] res;
        logic [12:0] a;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;

        for (int i = 0; i < DEPTH; i++) begin
            rom_m[i] = rom_init(i);
            ram_m[i] = ram_init(i);
            dut.u_rom.mem_q[i] = rom_init(i);
            dut.u_ram.mem_q[i] = ram_init(i);
        end

        vecs[0]  = '{13'h1004, 1'b1, 4'hF,    32'hDEADBEEF, 0,  1'b0, 32'h0};
        vecs[1]  = '{13'h1004, 1'b0, 4'h0,    32'h0,        0,  1'b0, 32'hDEADBEEF};
        vecs[2]  = '{13'h1004, 1'b1, 4'b0010, 32'h0000AA00, 0,  1'b0, 32'h0};
        vecs[3]  = '{13'h1004, 1'b0, 4'h0,    32'h0,        10, 1'b0, 32'hDEADAAEF};
        vecs[4]  = '{13'h0010, 1'b1, 4'hF,    32'h12345678, 2,  !ROMW, 32'h0};
        vecs[5]  = '{13'h0010, 1'b0, 4'h0,    32'h0,        0,  1'b0,
                     ROMW ? 32'h12345678 : 32'hC0DE0010};
        vecs[6]  = '{13'h1400, 1'b0, 4'h0,    32'h0,        10, 1'b1, 32'h0};
        vecs[7]  = '{13'h1004, 1'b1, 4'h0,    32'hFFFFFFFF, 0,  1'b0, 32'h0};
        vecs[8]  = '{13'h1004, 1'b0, 4'h0,    32'h0,        0,  1'b0, 32'hDEADAAEF};
        vecs[9]  = '{13'h0400, 1'b0, 4'h0,    32'h0,        0,  1'b1, 32'h0};
        vecs[10] = '{13'h1FFF, 1'b1, 4'hF,    32'h55555555, 0,  1'b1, 32'h0};
        vecs[11] = '{13'h03FF, 1'b0, 4'h0,    32'h0,        1,  1'b0, 32'hC0DE03FF};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            res = model(vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata);
            do_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].we, vecs[i].be,
                   vecs[i].wdata, vecs[i].hold, vecs[i].err, vecs[i].rdata);
        end

        // Abort a RAM write while it is still counting wait states.
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 13'h1008;
        req_we    = 1'b1;
        req_be    = 4'hF;
        req_wdata = 32'h11112222;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort req_ready", 32'(req_ready), 32'd0);
        chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort rsp_err", 32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort release req_ready", 32'(req_ready), 32'd1);
        $display("TXN abort_in_wait addr=1008 we=1 dropped by reset");
        res = model(13'h1008, 1'b0, 4'h0, 32'h0);
        do_txn("after_abort", 13'h1008, 1'b0, 4'h0, 32'h0, 0, res[32], res[31:0]);

        for (int t = 0; t < 60; t++) begin
            a        = 13'($urandom_range(0, 1100));
            a[12]    = 1'($urandom);
            we       = 1'($urandom);
            be       = 4'($urandom);
            wd       = $urandom;
            res      = model(a, we, be, wd);
            do_txn($sformatf("rnd%0d", t), a, we, be, wd, int'($urandom_range(0, 3)),
                   res[32], res[31:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
